// File: rtl/serial_frame_tx_if.sv
// Word handshake between an upstream producer and serial_frame_tx.
// The producer drives i_valid/i_data; the transmitter answers with o_ready.
interface serial_frame_tx_if #(
    parameter int WIDTH = 8
);
    logic             i_valid;
    logic [WIDTH-1:0] i_data;
    logic             o_ready;

    modport master (output i_valid, output i_data, input o_ready);
    modport slave  (input i_valid, input i_data, output o_ready);
endinterface

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: framed single-wire serial transmitter.
// Frame: start bit (0), WIDTH data bits LSB first, optional even parity bit,
// STOP_BITS stop bits (1). Each line bit is held CLKS_PER_BIT clocks.
// Optional feature: define SERIAL_FRAME_TX_PARITY_EN to insert the parity bit.
module serial_frame_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    serial_frame_tx_if.slave   s_if,
    output logic               o_data_a,
    output logic               o_busy,
    output logic               o_done
);

    localparam int BIT_W = $clog2(WIDTH + 1);
    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SERIAL_FRAME_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [DIV_W-1:0]   r_div, w_div_nxt;
    logic [BIT_W-1:0]   r_bit, w_bit_nxt;
    logic [WIDTH-1:0]   r_shift, w_shift_nxt;
    logic               r_line, w_line_nxt;
    logic               r_done, w_done_nxt;
    logic               w_tick;
    logic               w_last_data;
    logic               w_last_stop;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic               r_parity, w_parity_nxt;

    // Even parity: XOR of every captured data bit.
    function automatic logic f_even_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

    // End of the current line bit and end-of-sequence markers.
    assign w_tick      = (r_div == DIV_W'(CLKS_PER_BIT - 1));
    assign w_last_data = (r_bit == BIT_W'(WIDTH - 1));
    assign w_last_stop = (r_bit == BIT_W'(STOP_BITS - 1));

    // Next-state, counter, shift and line-level decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_done_nxt  = 1'b0;
        w_line_nxt  = 1'b1;
`ifdef SERIAL_FRAME_TX_PARITY_EN
        w_parity_nxt = r_parity;
`endif
        case (r_state)
            S_IDLE: begin
                w_div_nxt = '0;
                w_bit_nxt = '0;
                // o_ready is high throughout IDLE, so i_valid alone completes the handshake
                if (s_if.i_valid) begin
                    w_state_nxt = S_START;
                    w_shift_nxt = s_if.i_data;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    w_parity_nxt = f_even_parity(s_if.i_data);
`endif
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_div_nxt   = '0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_div_nxt   = '0;
                    w_shift_nxt = r_shift >> 1;
                    if (w_last_data) begin
                        w_bit_nxt = '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_nxt = r_bit + BIT_W'(1);
                    end
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            S_PARITY: begin
                if (w_tick) begin
                    w_div_nxt   = '0;
                    w_state_nxt = S_STOP;
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end
`endif
            S_STOP: begin
                // the bit counter is reused to count stop bits
                if (w_tick) begin
                    w_div_nxt = '0;
                    if (w_last_stop) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_bit_nxt = r_bit + BIT_W'(1);
                    end
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_div_nxt   = '0;
                w_bit_nxt   = '0;
            end
        endcase

        // line level for the coming cycle, so o_data_a leaves a flop
        case (w_state_nxt)
            S_START:  w_line_nxt = 1'b0;
            S_DATA:   w_line_nxt = w_shift_nxt[0];
`ifdef SERIAL_FRAME_TX_PARITY_EN
            S_PARITY: w_line_nxt = w_parity_nxt;
`endif
            default:  w_line_nxt = 1'b1;
        endcase
    end

    // State, counters, shift register and registered line/done outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_line  <= 1'b1;
            r_done  <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_line  <= w_line_nxt;
            r_done  <= w_done_nxt;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            r_parity <= w_parity_nxt;
`endif
        end
    end

    assign s_if.o_ready = (r_state == S_IDLE);
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = r_done;
    assign o_data_a     = r_line;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: two instances (CLKS_PER_BIT=4/STOP_BITS=1 and
// CLKS_PER_BIT=1/STOP_BITS=2) share the stimulus; a frame-level model builds
// the expected line sequence of each accepted word.
module tb_serial_frame_tx;

    localparam logic [3:0] IDLE_EXP = 4'b1001; // {ready,busy,done,line}
`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int FL_A = 45;
    localparam int FL_B = 13;
`else
    localparam int FL_A = 41;
    localparam int FL_B = 12;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;

    always #5 clk = ~clk;

    serial_frame_tx_if #(.WIDTH(8)) if_a ();
    serial_frame_tx_if #(.WIDTH(8)) if_b ();
    assign if_a.i_valid = valid;
    assign if_a.i_data  = data;
    assign if_b.i_valid = valid;
    assign if_b.i_data  = data;

    logic line_a, busy_a, done_a;
    logic line_b, busy_b, done_b;

    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .s_if(if_a),
        .o_data_a(line_a), .o_busy(busy_a), .o_done(done_a)
    );
    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .STOP_BITS(2)) dut_b (
        .i_clk(clk), .i_rst(rst), .s_if(if_b),
        .o_data_a(line_b), .o_busy(busy_b), .o_done(done_b)
    );

    logic [3:0] q0[$];
    logic [3:0] q1[$];
    logic [3:0] cur0 = IDLE_EXP;
    logic [3:0] cur1 = IDLE_EXP;
    logic       acc0 = 1'b0;
    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int base   = 0;
    logic rec_line_a[0:127];
    logic rec_done_a[0:127];
    logic rec_rdy_a[0:127];
    logic rec_line_b[0:127];
    logic rec_done_b[0:127];

    // Expected per-cycle sequence for one frame, then the done/ready cycle.
    function automatic void add_frame(int m, logic [7:0] d, int cpb, int stops);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef SERIAL_FRAME_TX_PARITY_EN
        bits.push_back(^d);
`endif
        for (int i = 0; i < stops; i++) bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int c = 0; c < cpb; c++) begin
                if (m == 0) q0.push_back({3'b010, bits[k]});
                else        q1.push_back({3'b010, bits[k]});
            end
        end
        if (m == 0) q0.push_back(4'b1011);
        else        q1.push_back(4'b1011);
    endfunction

    task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, act, exp);
    endtask

    task automatic chk1(string name, logic act, logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got=%b expected=%b", name, act, exp);
    endtask

    task automatic clear_rec();
        for (int i = 0; i < 128; i++) begin
            rec_line_a[i] = 1'bx; rec_done_a[i] = 1'bx; rec_rdy_a[i] = 1'bx;
            rec_line_b[i] = 1'bx; rec_done_b[i] = 1'bx;
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic tick();
        int r;
        @(posedge clk);
        #1;
        cyc++;
        acc0 = 1'b0;
        if (rst) begin
            q0.delete(); q1.delete();
            cur0 = IDLE_EXP; cur1 = IDLE_EXP;
        end else begin
            if (valid && cur0[3]) begin add_frame(0, data, 4, 1); acc0 = 1'b1; end
            if (valid && cur1[3]) add_frame(1, data, 1, 2);
            if (q0.size() > 0) cur0 = q0.pop_front(); else cur0 = IDLE_EXP;
            if (q1.size() > 0) cur1 = q1.pop_front(); else cur1 = IDLE_EXP;
        end
        chk("dut_a", {if_a.o_ready, busy_a, done_a, line_a}, cur0);
        chk("dut_b", {if_b.o_ready, busy_b, done_b, line_b}, cur1);
        r = cyc - base;
        if (r >= 0 && r < 128) begin
            rec_line_a[r] = line_a; rec_done_a[r] = done_a; rec_rdy_a[r] = if_a.o_ready;
            rec_line_b[r] = line_b; rec_done_b[r] = done_b;
        end
    endtask

    task automatic send(logic [7:0] d, int n);
        clear_rec();
        valid = 1'b1;
        data  = d;
        base  = cyc;
        tick();
        valid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        clear_rec();
        // reset held two cycles with a word offered
        rst = 1'b1; valid = 1'b1; data = 8'h55;
        tick();
        tick();
        chk1("rst_ready", if_a.o_ready, 1'b1);
        chk1("rst_busy", busy_a, 1'b0);
        chk1("rst_line", line_a, 1'b1);
        rst = 1'b0; valid = 1'b0;
        repeat (3) tick();

        // single frame 0xA5
        send(8'hA5, 50);
        chk1("a5_start1", rec_line_a[1], 1'b0);
        chk1("a5_start4", rec_line_a[4], 1'b0);
        chk1("a5_bit0", rec_line_a[5], 1'b1);
        chk1("a5_bit1", rec_line_a[9], 1'b0);
        chk1("a5_bit7", rec_line_a[36], 1'b1);
`ifdef SERIAL_FRAME_TX_PARITY_EN
        chk1("a5_parity", rec_line_a[37], 1'b0);
`else
        chk1("a5_stop", rec_line_a[37], 1'b1);
`endif
        chk1("a5_nodone", rec_done_a[FL_A-1], 1'b0);
        chk1("a5_done", rec_done_a[FL_A], 1'b1);
        chk1("a5_ready", rec_rdy_a[FL_A], 1'b1);

        // back-to-back 0x00 then 0xFF with i_valid held high
        clear_rec();
        valid = 1'b1; data = 8'h00; base = cyc;
        tick();
        data = 8'hFF;
        for (int i = 0; i < 2 * FL_A + 8; i++) begin
            tick();
            if (acc0) valid = 1'b0;
        end
        valid = 1'b0;
        chk1("b2b_gap", rec_line_a[FL_A], 1'b1);
        chk1("b2b_done1", rec_done_a[FL_A], 1'b1);
        chk1("b2b_start2", rec_line_a[FL_A+1], 1'b0);
        chk1("b2b_data2", rec_line_a[FL_A+5], 1'b1);
        chk1("b2b_done2", rec_done_a[2*FL_A], 1'b1);
        repeat (20) tick();

`ifdef SERIAL_FRAME_TX_PARITY_EN
        send(8'h07, 50);
        chk1("p07_parity", rec_line_a[37], 1'b1);
        chk1("p07_stop", rec_line_a[44], 1'b1);
        chk1("p07_done", rec_done_a[45], 1'b1);
        send(8'h03, 50);
        chk1("p03_parity", rec_line_a[37], 1'b0);
`endif

        // reset in the middle of a frame
        clear_rec();
        valid = 1'b1; data = 8'h5A; base = cyc;
        tick();
        valid = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1("mid_rst_line", rec_line_a[11], 1'b1);
        chk1("mid_rst_ready", rec_rdy_a[11], 1'b1);
        repeat (40) tick();
        send(8'h3C, 50);
        chk1("after_rst_bit2", rec_line_a[13], 1'b1);
        chk1("after_rst_done", rec_done_a[FL_A], 1'b1);

        // one clock per bit, two stop bits, MSB-only word
        send(8'h80, 20);
        chk1("b80_start", rec_line_b[1], 1'b0);
        chk1("b80_bit6", rec_line_b[8], 1'b0);
        chk1("b80_msb", rec_line_b[9], 1'b1);
        chk1("b80_nodone", rec_done_b[FL_B-1], 1'b0);
        chk1("b80_done", rec_done_b[FL_B], 1'b1);
        repeat (5) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Transmitter end of the single-wire serial data link whose receiver samples i_data_a.
- Accepts a parallel word through a valid/ready handshake.
- Serialises the word onto o_data_a as a framed bit stream: start bit, data LSB first, optional parity, stop bit(s).
- Bit timing comes from an internal clock-divide counter; one clock domain only.

Parameters:
- WIDTH, 8: data word width in bits (1..32).
- CLKS_PER_BIT, 4: clock cycles each line bit is held (>=1).
- STOP_BITS, 1: number of stop bits (1 or 2).

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_valid  input  1  upstream has a word to send.
- i_data  input  WIDTH  word to send; sampled only on handshake.
- o_ready  output  1  transmitter can accept a word.
- o_data_a  output  1  serial line; idles high.
- o_busy  output  1  a frame is in progress.
- o_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (i_rst=1 at a rising edge): the next cycle shows state IDLE, o_data_a=1, o_ready=1, o_busy=0, o_done=0. Bit counter, divide counter and shift register clear to 0.
- Handshake: a word is accepted on an edge where i_valid=1 and o_ready=1. i_data is captured into the shift register at that edge. o_ready=1 only in IDLE; i_valid and i_data are ignored otherwise. i_valid may drop without a transfer and carries no penalty.
- States: IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE.
  - IDLE: o_data_a=1, o_busy=0. A handshake moves to START.
  - START: o_data_a=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: o_data_a = shift[0]; each bit is held CLKS_PER_BIT cycles, then the register shifts right. After WIDTH bits, go to PARITY if enabled, else STOP.
  - PARITY: o_data_a = parity bit for CLKS_PER_BIT cycles, then STOP.
  - STOP: o_data_a=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
- o_busy=1 in every state except IDLE.
- o_done=1 for exactly the first IDLE cycle after STOP. That same cycle has o_ready=1.
- o_data_a is registered, with no combinational path from inputs.
- Latency: the start bit appears on the cycle after acceptance.
- Frame length, no parity: (1+WIDTH+STOP_BITS)*CLKS_PER_BIT cycles. Back-to-back words leave exactly 1 idle-high cycle between frames (the done/ready cycle).
- Divide counter runs 0..CLKS_PER_BIT-1 and wraps on each bit boundary. CLKS_PER_BIT=1 gives one cycle per bit with no extra gap.
- Bit counter width is clog2(WIDTH+1); it must not overflow at WIDTH=32.
- Reset mid-frame: the frame is abandoned and the line returns high on the next cycle. No o_done pulse; the captured word is discarded.
- i_rst and a handshake on the same edge: reset wins and no word is accepted.

Optional Feature:
- Macro SERIAL_FRAME_TX_PARITY_EN.
- Defined: the PARITY state is inserted after DATA. Its bit is even parity, the XOR of all WIDTH captured data bits. Frame length grows by CLKS_PER_BIT.
- Undefined: the PARITY state and its logic are absent, and DATA goes directly to STOP.

Test Plan:
- Reset: hold i_rst 2 cycles with i_valid=1 -> o_data_a=1, o_ready=1, o_busy=0, o_done=0 throughout; no frame starts.
- Single frame, WIDTH=8, CLKS_PER_BIT=4, no parity: accept 0xA5 at edge 0 ->
  - cycles 1-4: line 0;
  - cycles 5-36: bits 1,0,1,0,0,1,0,1, 4 cycles each;
  - cycles 37-40: line 1;
  - cycle 41: o_done=1 and o_ready=1.
- Back-to-back: i_valid held high with 0x00 then 0xFF -> second start bit at cycle 42. Exactly one high cycle between frames; o_done pulses at 41 and 82.
- Parity build: send 0x07 -> parity bit 1 during cycles 37-40, stop during cycles 41-44, o_done at 45. Send 0x03 -> parity bit 0.
- Reset mid-frame: assert i_rst at cycle 10 of a frame -> line 1 from cycle 11, o_ready=1, no o_done. A new word sent afterwards is transmitted correctly.
- Edges of range: CLKS_PER_BIT=1, STOP_BITS=2, send 0x80 -> frame lasts 11 cycles with MSB 1 in the last data slot; o_done at cycle 12.
